// File: rtl/enc_line_trig_gen.sv
// Quadrature encoder to line-trigger generator: synchronises A/B, decodes counts,
// divides them into fixed-width trigger pulses and supervises the trigger period.
module enc_line_trig_gen #(
    parameter int CNT_W       = 32,
    parameter int DIV_W       = 8,
    parameter int PULSE_W     = 8,
    parameter int BACK_W      = 16,
    parameter int STOP_ON_ERR = 1
) (
    input  logic               clk_8m,
    input  logic               rst_n,
    input  logic               enable,
    input  logic [1:0]         mode,
    input  logic               dir_filter,
    input  logic [DIV_W-1:0]   div_ratio,
    input  logic [PULSE_W-1:0] pulse_len,
    input  logic [CNT_W-1:0]   min_period,
    input  logic [CNT_W-1:0]   max_period,
    input  logic               clr_err,
    input  logic               encoder_a,
    input  logic               encoder_b,
    output logic               line_trig,
    output logic               dir,
    output logic [CNT_W-1:0]   period,
    output logic [CNT_W-1:0]   line_cnt,
    output logic               warning,
    output logic               error,
    output logic               quad_err
);

    logic a_s1_q, a_s2_q, a_h_q;
    logic b_s1_q, b_s2_q, b_h_q;

    logic [DIV_W-1:0]   div_cnt_q,   div_cnt_d;
    logic [BACK_W-1:0]  backlog_q,   backlog_d;
    logic [PULSE_W-1:0] pulse_cnt_q, pulse_cnt_d;
    logic [CNT_W-1:0]   pcnt_q,      pcnt_d;
    logic [CNT_W-1:0]   period_q,    period_d;
    logic [CNT_W-1:0]   line_cnt_q,  line_cnt_d;
    logic               seen_q,      seen_d;
    logic               warning_q,   warning_d;
    logic               error_q,     error_d;
    logic               quad_err_q,  quad_err_d;
    logic               dir_q,       dir_d;
    logic               line_trig_q, line_trig_d;

    logic               a_chg, b_chg, ev, fwd, qerr_set, cnt_ev, dec_trig, trig, err_set;
    logic [DIV_W-1:0]   div_eff;
    logic [PULSE_W-1:0] pulse_eff;

    always_comb begin
        a_chg    = a_s2_q ^ a_h_q;
        b_chg    = b_s2_q ^ b_h_q;
        ev       = 1'b0;
        fwd      = 1'b0;
        qerr_set = 1'b0;
        // Forward means A leads B: on an A edge A!=B afterwards, on a B edge A==B.
        if (enable) begin
            case (mode)
                2'b01: begin
                    ev  = a_chg && a_s2_q;
                    fwd = a_s2_q ^ b_s2_q;
                end
                2'b10: begin
                    ev  = a_chg;
                    fwd = a_s2_q ^ b_s2_q;
                end
                2'b11: begin
                    if (a_chg && b_chg) begin
                        qerr_set = 1'b1;
                    end else if (a_chg) begin
                        ev  = 1'b1;
                        fwd = a_s2_q ^ b_s2_q;
                    end else if (b_chg) begin
                        ev  = 1'b1;
                        fwd = ~(a_s2_q ^ b_s2_q);
                    end
                end
                default: ;
            endcase
        end

        div_eff   = (div_ratio == '0) ? DIV_W'(1) : div_ratio;
        pulse_eff = (pulse_len == '0) ? PULSE_W'(1) : pulse_len;

        backlog_d = backlog_q;
        cnt_ev    = 1'b0;
        if (!dir_filter) begin
            backlog_d = '0;
            cnt_ev    = ev;
        end else if (ev) begin
            if (!fwd) begin
                if (backlog_q != '1) backlog_d = backlog_q + BACK_W'(1);
            end else if (backlog_q != '0) begin
                backlog_d = backlog_q - BACK_W'(1);
            end else begin
                cnt_ev = 1'b1;
            end
        end

        div_cnt_d = div_cnt_q;
        dec_trig  = 1'b0;
        if (cnt_ev) begin
            if (div_cnt_q >= div_eff - DIV_W'(1)) begin
                dec_trig  = 1'b1;
                div_cnt_d = '0;
            end else begin
                div_cnt_d = div_cnt_q + DIV_W'(1);
            end
        end
        trig = (mode == 2'b00) ? (enable && a_s2_q && !a_h_q) : dec_trig;

        pulse_cnt_d = pulse_cnt_q;
        if (dec_trig)                 pulse_cnt_d = pulse_eff;
        else if (pulse_cnt_q != '0)   pulse_cnt_d = pulse_cnt_q - PULSE_W'(1);

        dir_d = ev ? fwd : dir_q;

        pcnt_d     = (pcnt_q == '1) ? pcnt_q : pcnt_q + CNT_W'(1);
        period_d   = period_q;
        line_cnt_d = line_cnt_q;
        seen_d     = seen_q;
        warning_d  = warning_q;
        err_set    = 1'b0;
        // The first trigger after enable only arms the measurement.
        if (trig) begin
            pcnt_d     = CNT_W'(1);
            line_cnt_d = line_cnt_q + CNT_W'(1);
            seen_d     = 1'b1;
            if (seen_q) begin
                period_d  = pcnt_q;
                err_set   = pcnt_q < min_period;
                warning_d = pcnt_q > max_period;
            end
        end else if (seen_q && (pcnt_q > max_period)) begin
            warning_d = 1'b1;
        end

        if (!enable) begin
            div_cnt_d   = '0;
            backlog_d   = '0;
            pulse_cnt_d = '0;
            pcnt_d      = '0;
            line_cnt_d  = '0;
            warning_d   = 1'b0;
            seen_d      = 1'b0;
        end

        error_d    = clr_err ? 1'b0 : (error_q | err_set);
        quad_err_d = clr_err ? 1'b0 : (quad_err_q | qerr_set);

        line_trig_d = enable && !((STOP_ON_ERR != 0) && error_d) &&
                      ((mode == 2'b00) ? a_s2_q : (pulse_cnt_d != '0));
    end

    always_ff @(posedge clk_8m) begin
        if (!rst_n) begin
            a_s1_q      <= 1'b0;
            a_s2_q      <= 1'b0;
            a_h_q       <= 1'b0;
            b_s1_q      <= 1'b0;
            b_s2_q      <= 1'b0;
            b_h_q       <= 1'b0;
            div_cnt_q   <= '0;
            backlog_q   <= '0;
            pulse_cnt_q <= '0;
            pcnt_q      <= '0;
            period_q    <= '0;
            line_cnt_q  <= '0;
            seen_q      <= 1'b0;
            warning_q   <= 1'b0;
            error_q     <= 1'b0;
            quad_err_q  <= 1'b0;
            dir_q       <= 1'b0;
            line_trig_q <= 1'b0;
        end else begin
            a_s1_q      <= encoder_a;
            a_s2_q      <= a_s1_q;
            a_h_q       <= a_s2_q;
            b_s1_q      <= encoder_b;
            b_s2_q      <= b_s1_q;
            b_h_q       <= b_s2_q;
            div_cnt_q   <= div_cnt_d;
            backlog_q   <= backlog_d;
            pulse_cnt_q <= pulse_cnt_d;
            pcnt_q      <= pcnt_d;
            period_q    <= period_d;
            line_cnt_q  <= line_cnt_d;
            seen_q      <= seen_d;
            warning_q   <= warning_d;
            error_q     <= error_d;
            quad_err_q  <= quad_err_d;
            dir_q       <= dir_d;
            line_trig_q <= line_trig_d;
        end
    end

    assign line_trig = line_trig_q;
    assign dir       = dir_q;
    assign period    = period_q;
    assign line_cnt  = line_cnt_q;
    assign warning   = warning_q;
    assign error     = error_q;
    assign quad_err  = quad_err_q;

endmodule

// File: tb/tb_enc_line_trig_gen.sv
// Directed bench for enc_line_trig_gen: hand-computed expectations for decode,
// divide, pulse, period supervision, error clearing and reset behaviour.
module tb_enc_line_trig_gen;

    logic        clk_8m = 1'b0;
    logic        rst_n = 1'b0;
    logic        enable = 1'b0;
    logic [1:0]  mode = 2'b01;
    logic        dir_filter = 1'b0;
    logic [7:0]  div_ratio = 8'd3;
    logic [7:0]  pulse_len = 8'd4;
    logic [31:0] min_period = 32'd0;
    logic [31:0] max_period = 32'd100000;
    logic        clr_err = 1'b0;
    logic        encoder_a = 1'b0;
    logic        encoder_b = 1'b0;
    logic        line_trig, dir, warning, error, quad_err;
    logic [31:0] period, line_cnt;

    int n_vec = 0;
    int n_bad = 0;
    int rises = 0;
    int hi_cycles = 0;
    int base = 0;
    int hbase = 0;
    logic lt_prev = 1'b0;
    logic [1:0] idx = 2'd0;

    enc_line_trig_gen dut (
        .clk_8m(clk_8m), .rst_n(rst_n), .enable(enable), .mode(mode),
        .dir_filter(dir_filter), .div_ratio(div_ratio), .pulse_len(pulse_len),
        .min_period(min_period), .max_period(max_period), .clr_err(clr_err),
        .encoder_a(encoder_a), .encoder_b(encoder_b), .line_trig(line_trig),
        .dir(dir), .period(period), .line_cnt(line_cnt), .warning(warning),
        .error(error), .quad_err(quad_err)
    );

    always #5 clk_8m = ~clk_8m;

    always @(negedge clk_8m) begin
        if (line_trig && !lt_prev) rises++;
        if (line_trig) hi_cycles++;
        lt_prev = line_trig;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk_8m);
        #1;
    endtask

    task automatic a_pulse(input int half);
        encoder_a = 1'b1;
        tick(half);
        encoder_a = 1'b0;
        tick(half);
    endtask

    // Quadrature states in forward order: 00, 10, 11, 01.
    task automatic q_step(input bit f);
        idx = f ? idx + 2'd1 : idx - 2'd1;
        encoder_a = idx[0] ^ idx[1];
        encoder_b = idx[1];
        tick(10);
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_trig"}, {31'd0, line_trig}, 32'd0);
        chk({tag, "_dir"}, {31'd0, dir}, 32'd0);
        chk({tag, "_period"}, period, 32'd0);
        chk({tag, "_lcnt"}, line_cnt, 32'd0);
        chk({tag, "_warn"}, {31'd0, warning}, 32'd0);
        chk({tag, "_err"}, {31'd0, error}, 32'd0);
        chk({tag, "_qerr"}, {31'd0, quad_err}, 32'd0);
    endtask

    initial begin
        // Reset state
        tick(3);
        chk_all_zero("rst");
        rst_n = 1'b1;

        // x1 decode, divide by 3, 4-cycle pulses, 80 cycles per A rise
        mode = 2'b01; div_ratio = 8'd3; pulse_len = 8'd4; enable = 1'b1;
        tick(2);
        base = rises; hbase = hi_cycles;
        a_pulse(40);
        a_pulse(40);
        encoder_a = 1'b1;
        tick(2);
        chk("x1_lat_k1", {31'd0, line_trig}, 32'd0);
        tick(1);
        chk("x1_lat_k2", {31'd0, line_trig}, 32'd1);
        chk("x1_first_period", period, 32'd0);
        tick(3);
        chk("x1_pulse_end_hi", {31'd0, line_trig}, 32'd1);
        tick(1);
        chk("x1_pulse_end_lo", {31'd0, line_trig}, 32'd0);
        tick(33);
        encoder_a = 1'b0;
        tick(40);
        for (int i = 0; i < 6; i++) a_pulse(40);
        chk("x1_rises", rises - base, 32'd3);
        chk("x1_hi_cycles", hi_cycles - hbase, 32'd12);
        chk("x1_period", period, 32'd240);
        chk("x1_line_cnt", line_cnt, 32'd3);
        chk("x1_dir", {31'd0, dir}, 32'd1);
        enable = 1'b0;
        tick(2);
        chk("dis_line_cnt", line_cnt, 32'd0);
        chk("dis_period_held", period, 32'd240);

        // x4 with reverse backlog
        mode = 2'b11; div_ratio = 8'd4; pulse_len = 8'd2; dir_filter = 1'b1;
        encoder_a = 1'b0; encoder_b = 1'b0; idx = 2'd0;
        enable = 1'b1;
        tick(3);
        base = rises;
        for (int i = 0; i < 8; i++) q_step(1'b1);
        chk("x4_fwd8_rises", rises - base, 32'd2);
        chk("x4_fwd8_dir", {31'd0, dir}, 32'd1);
        for (int i = 0; i < 5; i++) q_step(1'b0);
        chk("x4_rev5_rises", rises - base, 32'd2);
        chk("x4_rev5_dir", {31'd0, dir}, 32'd0);
        for (int i = 0; i < 8; i++) q_step(1'b1);
        chk("x4_fwd8b_rises", rises - base, 32'd2);
        q_step(1'b1);
        chk("x4_fwd9_rises", rises - base, 32'd3);
        chk("x4_dir_back", {31'd0, dir}, 32'd1);
        chk("x4_line_cnt", line_cnt, 32'd3);

        // Overspeed: sticky error, suppression, clearing
        enable = 1'b0;
        encoder_a = 1'b0; encoder_b = 1'b0;
        tick(3);
        mode = 2'b01; div_ratio = 8'd1; pulse_len = 8'd4; dir_filter = 1'b0;
        min_period = 32'd100; enable = 1'b1;
        tick(1);
        base = rises;
        a_pulse(30);
        chk("ovs_first_rises", rises - base, 32'd1);
        chk("ovs_first_err", {31'd0, error}, 32'd0);
        a_pulse(30);
        chk("ovs_err_set", {31'd0, error}, 32'd1);
        chk("ovs_suppressed", rises - base, 32'd1);
        clr_err = 1'b1;
        tick(1);
        clr_err = 1'b0;
        chk("ovs_cleared", {31'd0, error}, 32'd0);
        tick(59);
        a_pulse(30);
        chk("ovs_resume_err", {31'd0, error}, 32'd0);
        chk("ovs_resume_rises", rises - base, 32'd2);
        encoder_a = 1'b1;
        tick(2);
        clr_err = 1'b1;
        tick(1);
        clr_err = 1'b0;
        tick(27);
        encoder_a = 1'b0;
        tick(30);
        chk("ovs_clr_wins", {31'd0, error}, 32'd0);
        chk("ovs_clr_wins_rises", rises - base, 32'd3);

        // Underspeed and stall warning
        enable = 1'b0;
        tick(1);
        min_period = 32'd0; max_period = 32'd500; enable = 1'b1;
        a_pulse(150);
        encoder_a = 1'b1;
        tick(503);
        chk("stall_before", {31'd0, warning}, 32'd0);
        tick(1);
        chk("stall_after", {31'd0, warning}, 32'd1);
        tick(200);
        encoder_a = 1'b0;
        tick(10);
        encoder_a = 1'b1;
        tick(150);
        chk("slow_trig_warn", {31'd0, warning}, 32'd1);
        encoder_a = 1'b0;
        tick(150);
        encoder_a = 1'b1;
        tick(5);
        chk("resume_warn", {31'd0, warning}, 32'd0);
        chk("resume_period", period, 32'd300);

        // Illegal quadrature jump, then div_ratio=0 in x2
        encoder_a = 1'b0; encoder_b = 1'b0; enable = 1'b0;
        tick(5);
        mode = 2'b11; div_ratio = 8'd1; pulse_len = 8'd2; max_period = 32'd100000;
        enable = 1'b1;
        tick(2);
        base = rises;
        encoder_b = 1'b1;
        tick(10);
        chk("q_rev_dir", {31'd0, dir}, 32'd0);
        chk("q_rev_rises", rises - base, 32'd1);
        encoder_a = 1'b1; encoder_b = 1'b0;
        tick(10);
        chk("q_jump_qerr", {31'd0, quad_err}, 32'd1);
        chk("q_jump_dir", {31'd0, dir}, 32'd0);
        chk("q_jump_rises", rises - base, 32'd1);
        chk("q_jump_lcnt", line_cnt, 32'd1);
        clr_err = 1'b1;
        tick(1);
        clr_err = 1'b0;
        chk("q_clr", {31'd0, quad_err}, 32'd0);
        mode = 2'b10; div_ratio = 8'd0;
        for (int i = 0; i < 4; i++) begin
            encoder_a = ~encoder_a;
            tick(10);
        end
        chk("x2_div0_rises", rises - base, 32'd5);
        chk("x2_div0_lcnt", line_cnt, 32'd5);
        chk("x2_div0_dir", {31'd0, dir}, 32'd1);

        // Reset mid-pulse with error set
        encoder_a = 1'b0; encoder_b = 1'b0; enable = 1'b0;
        tick(5);
        mode = 2'b01; div_ratio = 8'd1; pulse_len = 8'd8; min_period = 32'd100;
        enable = 1'b1;
        tick(1);
        a_pulse(30);
        encoder_a = 1'b1;
        tick(3);
        chk("pre_rst_err", {31'd0, error}, 32'd1);
        encoder_a = 1'b0;
        tick(2);
        rst_n = 1'b0;
        tick(1);
        rst_n = 1'b1;
        chk_all_zero("midrst");
        base = rises;
        a_pulse(30);
        chk("post_rst_err", {31'd0, error}, 32'd0);
        chk("post_rst_period", period, 32'd0);
        chk("post_rst_lcnt", line_cnt, 32'd1);
        chk("post_rst_rises", rises - base, 32'd1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
